// File: rtl/vmem_pkg.sv
// Shared constants and FSM state type for the vector memory responder.
package vmem_pkg;

  localparam int unsigned LINE_W = 512;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEATS  = 16;
  localparam int unsigned ADDR_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StResp
  } state_e;

endpackage

// File: rtl/vmem_line_buffer.sv
// Line-wide data register, written one SRAM beat slice at a time.
module vmem_line_buffer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BEATS  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(BEATS)-1:0]   wr_idx,
  input  logic [WORD_W-1:0]          wr_data,
  output logic [WORD_W*BEATS-1:0]    line
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      line <= '0;
    end else if (wr_en) begin
      line[WORD_W*wr_idx +: WORD_W] <= wr_data;
    end
  end

endmodule

// File: rtl/vmem_responder.sv
// Splits 512-bit line loads/stores into sequential single-port SRAM beats,
// one request in flight at a time.
module vmem_responder #(
  parameter int unsigned WORD_W = vmem_pkg::WORD_W,
  parameter int unsigned BEATS  = vmem_pkg::BEATS,
  parameter int unsigned ADDR_W = vmem_pkg::ADDR_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [vmem_pkg::LINE_W-1:0]       req_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [vmem_pkg::LINE_W-1:0]       rsp_rdata,
  output logic                              sram_en,
  output logic                              sram_we,
  output logic [ADDR_W+$clog2(BEATS)-1:0]   sram_addr,
  output logic [WORD_W-1:0]                 sram_wdata,
  input  logic [WORD_W-1:0]                 sram_rdata
);

  import vmem_pkg::*;

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic                lb_clear;
  logic                lb_wr_en;
  logic [BEAT_W-1:0]   lb_wr_idx;

  assign beat_nxt = beat_q + BEAT_W'(1);

  // Read data lags its access by one cycle, so READ captures the previous
  // beat and DRAIN picks up the final one.
  always_comb begin
    lb_clear  = (state_q == StIdle) && req_valid;
    lb_wr_en  = ((state_q == StRead) && (beat_q != '0)) || (state_q == StDrain);
    lb_wr_idx = (state_q == StDrain) ? LAST_BEAT : beat_q - BEAT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            beat_q     <= '0;
            req_ready  <= 1'b0;
            sram_en    <= 1'b1;
            sram_we    <= req_we;
            sram_addr  <= {req_addr, {BEAT_W{1'b0}}};
            sram_wdata <= req_wdata[WORD_W-1:0];
            state_q    <= req_we ? StWrite : StRead;
          end
        end
        StWrite, StRead: begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            if (state_q == StWrite) begin
              rsp_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              state_q   <= StDrain;
            end
          end else begin
            beat_q     <= beat_nxt;
            sram_addr  <= {addr_q, beat_nxt};
            sram_wdata <= wdata_q[WORD_W*beat_nxt +: WORD_W];
          end
        end
        StDrain: begin
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  vmem_line_buffer #(
    .WORD_W (WORD_W),
    .BEATS  (BEATS)
  ) u_line_buffer (
    .clock   (clock),
    .reset   (reset),
    .clear   (lb_clear),
    .wr_en   (lb_wr_en),
    .wr_idx  (lb_wr_idx),
    .wr_data (sram_rdata),
    .line    (rsp_rdata)
  );

endmodule

// File: tb/tb_vmem_responder.sv
// Scoreboard bench: stimulus queues expected SRAM beats and responses,
// forked monitors pop and compare whatever the DUT presents.
module tb_vmem_responder;

  typedef struct packed {
    bit          we;
    logic [12:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [511:0] rdata;
    int           lat;
  } rsp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [8:0]   req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [511:0] rsp_rdata;
  logic         sram_en;
  logic         sram_we;
  logic [12:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic [31:0]  sram_rdata = '0;

  bit [31:0] mem [8192];
  bit        wr  [8192];
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  acc_t      exp_acc [$];
  rsp_t      exp_rsp [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  vmem_responder dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  function automatic logic [31:0] init_word(input logic [12:0] a);
    return 32'hC0DE_0000 | {19'd0, a};
  endfunction

  function automatic logic [31:0] peek(input logic [12:0] a);
    return wr[a] ? mem[a] : init_word(a);
  endfunction

  // Behavioural SRAM: never-written words read back a known address pattern.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        wr[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= peek(sram_addr);
      end
    end
  end

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_line(input bit we, input logic [8:0] addr, input logic [511:0] wd,
                           input logic [511:0] rd, input int lat, input int nbeats);
    acc_t a;
    rsp_t r;
    for (int i = 0; i < nbeats; i++) begin
      a.we   = we;
      a.addr = {addr, 4'(i)};
      a.data = wd[32*i +: 32];
      exp_acc.push_back(a);
    end
    if (lat > 0) begin
      r.rdata = rd;
      r.lat   = lat;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic mon_acc();
    acc_t e;
    forever begin
      @(negedge clock);
      if (!reset && sram_en) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL sram_access: unexpected we=%0b addr=%h", sram_we, sram_addr);
        end else begin
          e = exp_acc.pop_front();
          if (sram_we !== e.we || sram_addr !== e.addr || (e.we && sram_wdata !== e.data)) begin
            errors++;
            $display("FAIL sram_access: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     sram_we, sram_addr, sram_wdata, e.we, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic mon_rsp();
    int           acc_cyc = 0;
    bit           prev = 1'b0;
    logic [511:0] held = '0;
    rsp_t         e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (req_valid && req_ready) acc_cyc = cyc;
        if (rsp_valid) begin
          if (!prev) begin
            held = rsp_rdata;
            checks++;
            if (exp_rsp.size() == 0) begin
              errors++;
              $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else if (cyc - acc_cyc != exp_rsp[0].lat) begin
              errors++;
              $display("FAIL rsp_latency: got %0d expected %0d", cyc - acc_cyc, exp_rsp[0].lat);
            end
          end else begin
            check("rsp_stable", rsp_rdata, held);
          end
          check("req_ready_in_resp", {511'd0, req_ready}, 512'd0);
          if (rsp_ready && exp_rsp.size() != 0) begin
            e = exp_rsp.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
          end
        end
        prev = rsp_valid;
      end
    end
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (req_ready) ok = 1'b1;
    end
    check(name, {511'd0, ok}, 512'd1);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (exp_rsp.size() == 0) ok = 1'b1;
    end
    check(name, {511'd0, ok}, 512'd1);
    if (!ok) begin
      exp_rsp.delete();
      exp_acc.delete();
    end
  endtask

  task automatic send(input bit we, input logic [8:0] addr, input logic [511:0] wd);
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    wait_accept("accept");
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] wd;
    bit           ok;
    fork
      mon_acc();
      mon_rsp();
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready",  {511'd0, req_ready}, 512'd1);
    check("rst_rsp_valid",  {511'd0, rsp_valid}, 512'd0);
    check("rst_sram_en",    {511'd0, sram_en},   512'd0);
    check("rst_sram_we",    {511'd0, sram_we},   512'd0);
    check("rst_sram_addr",  {499'd0, sram_addr}, 512'd0);
    check("rst_sram_wdata", {480'd0, sram_wdata}, 512'd0);
    check("rst_rsp_rdata",  rsp_rdata, 512'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Store line to 0x005: beats land at 0x050..0x05F, response data is zero.
    wd = make_line(32'hA000_0000);
    push_line(1'b1, 9'h005, wd, '0, 17, 16);
    send(1'b1, 9'h005, wd);
    wait_drain("store_rsp");

    // Load it back while holding off the response.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    push_line(1'b0, 9'h005, '0, make_line(32'hA000_0000), 18, 16);
    send(1'b0, 9'h005, make_line(32'h1234_0000));
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clock);
      if (rsp_valid) ok = 1'b1;
    end
    check("load_rsp_seen", {511'd0, ok}, 512'd1);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_drain("load_rsp");

    // Back-to-back loads with req_valid held; address changes mid-access.
    push_line(1'b0, 9'h005, '0, make_line(32'hA000_0000), 18, 16);
    push_line(1'b0, 9'h1FF, '0, make_line(32'hC0DE_1FF0), 18, 16);
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h005;
    req_wdata = make_line(32'h5555_0000);
    wait_accept("b2b_first");
    repeat (6) @(posedge clock);
    #1;
    req_addr = 9'h1FF;
    wait_accept("b2b_second");
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_drain("b2b_rsp");

    // Reset during a store: only beats 0..6 reach the SRAM, no response.
    wd = make_line(32'hB000_0000);
    push_line(1'b1, 9'h0A0, wd, '0, 0, 7);
    send(1'b1, 9'h0A0, wd);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clock);
      if (sram_en && sram_addr[3:0] == 4'd6) ok = 1'b1;
    end
    check("abort_reached_beat6", {511'd0, ok}, 512'd1);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_sram_en",   {511'd0, sram_en},   512'd0);
    check("abort_rsp_valid", {511'd0, rsp_valid}, 512'd0);
    check("abort_idle",      {511'd0, req_ready}, 512'd1);
    check("abort_rsp_rdata", rsp_rdata, 512'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("abort_mem_%0d", i), {480'd0, peek({9'h0A0, 4'(i)})},
            {480'd0, (i < 7) ? 32'hB000_0000 + 32'(i) : 32'hC0DE_0A00 + 32'(i)});
    end

    repeat (5) @(negedge clock);
    check("acc_queue_empty", 512'(exp_acc.size()), 512'd0);
    check("rsp_queue_empty", 512'(exp_rsp.size()), 512'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_responder.md
VMEM_RESPONDER -- requirements
Module: vmem_responder

Interface
REQ-001 Parameter WORD_W, default 32, SRAM beat width in bits.
REQ-002 Parameter BEATS, default 16, beats per 512-bit vector line (WORD_W*BEATS SHALL equal 512).
REQ-003 Parameter ADDR_W, default 9, vector line address width.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  CPU-side request present.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_we  in  1  1 = store line, 0 = load line.
REQ-009 req_addr  in  ADDR_W  vector line address.
REQ-010 req_wdata  in  512  store data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  CPU consumes response.
REQ-013 rsp_rdata  out  512  load data; all-zero for store responses.
REQ-014 sram_en  out  1  SRAM beat access enable.
REQ-015 sram_we  out  1  SRAM beat write enable; meaningful only when sram_en=1.
REQ-016 sram_addr  out  ADDR_W+4  {line address, beat index}.
REQ-017 sram_wdata  out  WORD_W  store beat data.
REQ-018 sram_rdata  in  WORD_W  read data, valid the cycle after the read's sram_en cycle.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DRAIN, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-021 On accept, req_we, req_addr and req_wdata SHALL be latched; the next state is WRITE if req_we=1, otherwise READ; the beat counter is 0.
REQ-022 WRITE: each cycle sram_en=1, sram_we=1, sram_addr={addr,beat}, sram_wdata=line[WORD_W*beat +: WORD_W]; beat 0 carries bits 31:0.
REQ-023 READ: each cycle sram_en=1, sram_we=0, sram_addr={addr,beat}.
REQ-024 Read data from beat k's access SHALL be written into line-buffer slice k on the edge ending the following cycle.
REQ-025 The beat counter SHALL increment per beat; after beat BEATS-1 it wraps to 0 and the FSM moves WRITE->RESP or READ->DRAIN.
REQ-026 DRAIN: sram_en=0; capture beat BEATS-1; next state RESP.
REQ-027 Latency, counted from the accept edge: store rsp_valid first high in cycle 17; load rsp_valid first high in cycle 18.
REQ-028 RESP: rsp_valid=1, and rsp_rdata is stable until the edge where rsp_ready=1; the FSM then returns to IDLE, with req_ready=1 in the following cycle.
REQ-029 At most one request SHALL be outstanding; there is no accept in RESP even when rsp_ready=1 on the same edge.
REQ-030 sram_en SHALL be 0 in IDLE, DRAIN and RESP.
REQ-031 req_* inputs SHALL be ignored outside IDLE; changes after accept SHALL not affect the access in flight.

Reset
REQ-032 While reset=1 at an edge: state=IDLE, beat=0, line buffer=0, rsp_valid=0, sram_en=0, sram_we=0.
REQ-033 Outputs after reset: req_ready=1, rsp_rdata=0, sram_addr=0, sram_wdata=0.
REQ-034 Reset mid-operation SHALL abandon the access with no response; SRAM beats already written are left in place.

Structure
REQ-035 Package vmem_pkg SHALL hold LINE_W=512, WORD_W, BEATS, ADDR_W and the state enum.
REQ-036 Sub-module vmem_line_buffer (512-bit register with per-beat slice write and clear) SHALL hold the line data.

Verification
REQ-037 Store addr=9'h005, wdata word i = 32'hA000_0000+i -> 16 writes to sram_addr 13'h050..13'h05F with matching data; rsp_valid in cycle 17; rsp_rdata=0.
REQ-038 Load addr=9'h005 after REQ-037, with a behavioural 1-cycle SRAM model -> reads 13'h050..13'h05F; rsp_valid in cycle 18; rsp_rdata word i = 32'hA000_0000+i.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable; req_ready=0; accept occurs only in the cycle after rsp_ready=1.
REQ-040 Load addr=9'h1FF -> last access is sram_addr 13'h1FFF; the beat counter wraps to 0 with no extra SRAM access.
REQ-041 Assert reset at beat 7 of a store -> the next cycle shows IDLE, sram_en=0, rsp_valid=0; SRAM beats 0..6 written and 7..15 untouched.
REQ-042 Back-to-back requests with req_valid held high and req_addr changed mid-access -> the second request is accepted only after the first response and uses the address present at its own accept.
